// File: rtl/datamem_sized.sv
// rtl/datamem_sized.sv - byte-addressable RV64 data memory with sized access, fault detection and a hardware clear sequencer
//
// Purpose:
//   Byte-addressable data memory for the RISC-V cores. It supports every RV64
//   load/store size, with sign or zero extension on loads. Misaligned,
//   out-of-range and illegal-funct3 accesses are rejected. Each accepted
//   request returns exactly one response, LAT cycles after it is accepted.
//   After reset, a sequencer zeroes the array 8 bytes per cycle before the
//   block accepts any request.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake; accepted when both are high at a rising edge
//   req_write         1 = store, 0 = load
//   req_funct3        RISC-V size/sign code
//   req_addr          byte address (ADDR_W bits)
//   req_wdata         store data, LSB-aligned
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data; 0 for stores and faults
//   resp_fault        the access was rejected
//   resp_cause        00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
//   busy_clear        clear sequence in progress

module datamem_sized #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 64,
    parameter int LAT         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_fault,
    output logic [1:0]        resp_cause,
    output logic              busy_clear
);

    localparam int MAW    = $clog2(DEPTH_BYTES);
    localparam int NWORDS = DEPTH_BYTES / 8;
    localparam int CW     = $clog2(NWORDS);
    localparam logic [CW-1:0] CLR_LAST = CW'(NWORDS - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_clr_idx;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic              w_ready;
    logic [3:0]        w_size;
    logic [2:0]        w_amask;
    logic              w_illegal;
    logic              w_misal;
    logic              w_oor;
    logic [ADDR_W:0]   w_end;
    logic [1:0]        w_cause;
    logic              w_fault;
    logic              w_acc;
    logic              w_store;
    logic [MAW-1:0]    w_base;
    logic [63:0]       w_raw;
    logic [63:0]       w_ext;
    logic [63:0]       w_rd;

    // Response pipeline: stage 0 is captured at the accept edge, and the
    // output registers sit one stage after stage LAT-1.
    logic [LAT-1:0]        r_pv;
    logic [LAT-1:0]        r_pf;
    logic [LAT-1:0][1:0]   r_pc;
    logic [LAT-1:0][63:0]  r_pd;
    logic                  r_resp_valid;
    logic [63:0]           r_resp_rdata;
    logic                  r_resp_fault;
    logic [1:0]            r_resp_cause;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == CLR_LAST) w_next = S_IDLE;
            S_IDLE:  w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready    = (r_state == S_IDLE);
        busy_clear = (r_state == S_CLEAR);
    end

    assign req_ready = w_ready;

    // ---------------- request decode ----------------
    always_comb begin
        w_size    = 4'd1 << req_funct3[1:0];
        w_amask   = 3'b000;
        case (req_funct3[1:0])
            2'd0: w_amask = 3'b000;
            2'd1: w_amask = 3'b001;
            2'd2: w_amask = 3'b011;
            2'd3: w_amask = 3'b111;
            default: w_amask = 3'b000;
        endcase
        w_illegal = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
        w_misal   = (req_addr[2:0] & w_amask) != 3'b000;
        // The extra bit keeps addresses near 2^ADDR_W from wrapping into range.
        w_end     = {1'b0, req_addr} + (ADDR_W+1)'(w_size);
        w_oor     = w_end > (ADDR_W+1)'(DEPTH_BYTES);
        if (w_illegal)      w_cause = 2'b11;
        else if (w_misal)   w_cause = 2'b01;
        else if (w_oor)     w_cause = 2'b10;
        else                w_cause = 2'b00;
        w_fault = (w_cause != 2'b00);
    end

    // A request that arrives together with rst is dropped, even if req_ready is high.
    assign w_acc   = req_valid && w_ready && !rst;
    assign w_store = w_acc && req_write && !w_fault;
    assign w_base  = req_addr[MAW-1:0];

    // ---------------- read path ----------------
    // All 8 bytes are gathered, with the index wrapping inside the array. Only
    // in-range sized accesses use the result, so bytes that wrapped are never
    // visible.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 8; k++) begin
            w_raw[8*k +: 8] = r_mem[w_base + MAW'(k)];
        end
    end

    always_comb begin
        w_ext = '0;
        case (req_funct3)
            3'b000:  w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b011:  w_ext = w_raw;
            3'b100:  w_ext = {56'd0, w_raw[7:0]};
            3'b101:  w_ext = {48'd0, w_raw[15:0]};
            3'b110:  w_ext = {32'd0, w_raw[31:0]};
            default: w_ext = '0;
        endcase
        w_rd = (w_fault || req_write) ? 64'd0 : w_ext;
    end

    // ---------------- memory array: clear sequencer and stores ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                for (int k = 0; k < 8; k++) begin
                    r_mem[{r_clr_idx, 3'(k)}] <= 8'd0;
                end
            end else if (w_store) begin
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < w_size) begin
                        r_mem[w_base + MAW'(k)] <= req_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv         <= '0;
            r_pf         <= '0;
            r_pc         <= '0;
            r_pd         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_fault <= 1'b0;
            r_resp_cause <= 2'b00;
        end else begin
            r_pv[0] <= w_acc;
            r_pf[0] <= w_fault;
            r_pc[0] <= w_cause;
            r_pd[0] <= w_rd;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pc[i] <= r_pc[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            r_resp_valid <= r_pv[LAT-1];
            // The payload updates only with a valid beat, so it holds between responses.
            if (r_pv[LAT-1]) begin
                r_resp_rdata <= r_pd[LAT-1];
                r_resp_fault <= r_pf[LAT-1];
                r_resp_cause <= r_pc[LAT-1];
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign resp_cause = r_resp_cause;

endmodule
